// File: rtl/core_pkg.sv
// Shared core definitions: CSR access types, CSR address map, mstatus layout
// and the exception cause codes used by the trap logic.
package core_pkg;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_t;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

    // mtvec and mepc are word aligned; the low two bits always read zero.
    localparam logic [31:0] ALIGN4_MASK = 32'hFFFF_FFFC;

    localparam logic [4:0] EXC_CAUSE_INSTR_FAULT  = 5'h01;
    localparam logic [4:0] EXC_CAUSE_ILLEGAL_INSN = 5'h02;
    localparam logic [4:0] EXC_CAUSE_BREAKPOINT   = 5'h03;
    localparam logic [4:0] EXC_CAUSE_ECALL_MMODE  = 5'h0B;

    function automatic logic csr_is_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// CSR access bus between the decode/execute stage (master) and the CSR file.
interface csr_trap_unit_if;
    import core_pkg::*;

    csr_op_t     csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        illegal_csr_o;

    modport master (
        output csr_op_i, csr_addr_i, csr_wdata_i,
        input  csr_rdata_o, illegal_csr_o
    );

    modport slave (
        input  csr_op_i, csr_addr_i, csr_wdata_i,
        output csr_rdata_o, illegal_csr_o
    );

endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter whose 32-bit halves can be written individually;
// a half write replaces the increment for that cycle and the other half holds.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    // NOTE: registers are written with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            value <= '0;
        end else if (wr_lo) begin
            value[31:0] <= wdata;
        end else if (wr_hi) begin
            value[63:32] <= wdata;
        end else if (inc) begin
            value <= value + 64'd1;
        end
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/return handling and the mcycle/minstret
// counters. Reads are combinational; all updates land on the next clock edge.
module csr_trap_unit
    import core_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] MHARTID   = 32'h0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    csr_trap_unit_if.slave     csr,
    input  logic               save_pc_id_i,
    input  logic               save_pc_ex_i,
    input  logic [31:0]        pc_id_i,
    input  logic [31:0]        pc_ex_i,
    input  logic [4:0]         exception_cause_i,
    input  logic               is_mret_i,
    input  logic               instr_retired_i,
    output logic [31:0]        trap_target_o,
    output logic [31:0]        mepc_o,
    output logic               mie_o
);

    logic        mie_q, mpie_q;
    logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [63:0] mcycle, minstret;

    logic [31:0] mstatus_rd, old_val, new_val, trap_pc;
    logic        implemented, illegal, trap, csr_wr;

    always_comb begin
        mstatus_rd                                = '0;
        mstatus_rd[MSTATUS_MIE_BIT]               = mie_q;
        mstatus_rd[MSTATUS_MPIE_BIT]              = mpie_q;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        old_val     = '0;
        implemented = 1'b1;
        case (csr.csr_addr_i)
            CSR_MSTATUS:   old_val = mstatus_rd;
            CSR_MTVEC:     old_val = mtvec_q;
            CSR_MSCRATCH:  old_val = mscratch_q;
            CSR_MEPC:      old_val = mepc_q;
            CSR_MCAUSE:    old_val = mcause_q;
            CSR_MCYCLE:    old_val = mcycle[31:0];
            CSR_MCYCLEH:   old_val = mcycle[63:32];
            CSR_MINSTRET:  old_val = minstret[31:0];
            CSR_MINSTRETH: old_val = minstret[63:32];
            CSR_MHARTID:   old_val = MHARTID;
            default:       implemented = 1'b0;
        endcase
    end

    always_comb begin
        new_val = old_val;
        case (csr.csr_op_i)
            CSR_WRITE: new_val = csr.csr_wdata_i;
            CSR_SET:   new_val = old_val | csr.csr_wdata_i;
            CSR_CLEAR: new_val = old_val & ~csr.csr_wdata_i;
            default:   new_val = old_val;
        endcase
    end

    // Every op other than CSR_NONE modifies its target, so all count as writes.
    assign illegal = (csr.csr_op_i != CSR_NONE) &&
                     (!implemented || csr_is_read_only(csr.csr_addr_i));
    assign trap    = save_pc_ex_i | save_pc_id_i;
    assign trap_pc = save_pc_ex_i ? pc_ex_i : pc_id_i;
    assign csr_wr  = (csr.csr_op_i != CSR_NONE) && !illegal && !trap;

    assign csr.csr_rdata_o   = old_val;
    assign csr.illegal_csr_o = illegal;

    csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc     (1'b1),
        .wr_lo   (csr_wr && csr.csr_addr_i == CSR_MCYCLE),
        .wr_hi   (csr_wr && csr.csr_addr_i == CSR_MCYCLEH),
        .wdata   (new_val),
        .value   (mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc     (instr_retired_i),
        .wr_lo   (csr_wr && csr.csr_addr_i == CSR_MINSTRET),
        .wr_hi   (csr_wr && csr.csr_addr_i == CSR_MINSTRETH),
        .wdata   (new_val),
        .value   (minstret)
    );

    // A trap pre-empts both mret and any CSR write issued in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RST & ALIGN4_MASK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (trap) begin
            mepc_q   <= trap_pc & ALIGN4_MASK;
            mcause_q <= {27'b0, exception_cause_i};
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else begin
            if (is_mret_i) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end
            if (csr_wr) begin
                case (csr.csr_addr_i)
                    CSR_MSTATUS: begin
                        mie_q  <= new_val[MSTATUS_MIE_BIT];
                        mpie_q <= new_val[MSTATUS_MPIE_BIT];
                    end
                    CSR_MTVEC:    mtvec_q    <= new_val & ALIGN4_MASK;
                    CSR_MSCRATCH: mscratch_q <= new_val;
                    CSR_MEPC:     mepc_q     <= new_val & ALIGN4_MASK;
                    CSR_MCAUSE:   mcause_q   <= new_val;
                    default:      ;
                endcase
            end
        end
    end

    assign trap_target_o = {mtvec_q[31:2], 2'b00};
    assign mepc_o        = mepc_q;
    assign mie_o         = mie_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed and randomized checks of csr_trap_unit against a behavioural model
// of the machine-mode CSR state.
module tb_csr_trap_unit;
    import core_pkg::*;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
    localparam logic [31:0] MHARTID   = 32'h0;

    typedef struct {
        csr_op_t     op;
        logic [11:0] addr;
        logic [31:0] wdata;
        bit          sid;
        bit          sex;
        logic [31:0] pcid;
        logic [31:0] pcex;
        logic [4:0]  cause;
        bit          mret;
        bit          ret;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        save_pc_id, save_pc_ex, is_mret, instr_retired;
    logic [31:0] pc_id, pc_ex, trap_target, mepc, rd;
    logic [4:0]  cause;
    logic        mie;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state
    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_mcycle, m_minstret;

    csr_trap_unit_if bus ();

    csr_trap_unit #(.MTVEC_RST(MTVEC_RST), .MHARTID(MHARTID)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .csr               (bus),
        .save_pc_id_i      (save_pc_id),
        .save_pc_ex_i      (save_pc_ex),
        .pc_id_i           (pc_id),
        .pc_ex_i           (pc_ex),
        .exception_cause_i (cause),
        .is_mret_i         (is_mret),
        .instr_retired_i   (instr_retired),
        .trap_target_o     (trap_target),
        .mepc_o            (mepc),
        .mie_o             (mie)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.op = CSR_NONE; s.addr = CSR_MSCRATCH; s.wdata = '0;
        s.sid = 0; s.sex = 0; s.pcid = '0; s.pcex = '0; s.cause = '0;
        s.mret = 0; s.ret = 0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.csr_op_i    = s.op;
        bus.csr_addr_i  = s.addr;
        bus.csr_wdata_i = s.wdata;
        save_pc_id      = s.sid;
        save_pc_ex      = s.sex;
        pc_id           = s.pcid;
        pc_ex           = s.pcex;
        cause           = s.cause;
        is_mret         = s.mret;
        instr_retired   = s.ret;
    endtask

    task automatic model_reset();
        m_mie = 0; m_mpie = 0;
        m_mtvec = MTVEC_RST; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        m_mcycle = 0; m_minstret = 0;
    endtask

    function automatic bit m_known(input logic [11:0] a);
        return a inside {CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
                         CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH, CSR_MHARTID};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            CSR_MSTATUS:   return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            CSR_MTVEC:     return m_mtvec;
            CSR_MSCRATCH:  return m_mscratch;
            CSR_MEPC:      return m_mepc;
            CSR_MCAUSE:    return m_mcause;
            CSR_MCYCLE:    return m_mcycle[31:0];
            CSR_MCYCLEH:   return m_mcycle[63:32];
            CSR_MINSTRET:  return m_minstret[31:0];
            CSR_MINSTRETH: return m_minstret[63:32];
            CSR_MHARTID:   return MHARTID;
            default:       return 32'h0;
        endcase
    endfunction

    function automatic bit m_illegal(input csr_op_t op, input logic [11:0] a);
        return (op != CSR_NONE) && (!m_known(a) || a[11:10] == 2'b11);
    endfunction

    // Applies one clock edge worth of architectural effects to the model.
    task automatic model_edge(input stim_t s);
        logic [31:0] old_v, nv;
        logic [63:0] cyc_nx, ins_nx;
        bit          trap, wr;
        old_v  = m_read(s.addr);
        trap   = s.sid || s.sex;
        wr     = (s.op != CSR_NONE) && !m_illegal(s.op, s.addr) && !trap;
        nv     = (s.op == CSR_WRITE) ? s.wdata :
                 (s.op == CSR_SET)   ? (old_v | s.wdata) : (old_v & ~s.wdata);
        cyc_nx = m_mcycle + 64'd1;
        ins_nx = s.ret ? m_minstret + 64'd1 : m_minstret;
        if (wr) begin
            if (s.addr == CSR_MCYCLE)    cyc_nx = {m_mcycle[63:32], nv};
            if (s.addr == CSR_MCYCLEH)   cyc_nx = {nv, m_mcycle[31:0]};
            if (s.addr == CSR_MINSTRET)  ins_nx = {m_minstret[63:32], nv};
            if (s.addr == CSR_MINSTRETH) ins_nx = {nv, m_minstret[31:0]};
        end
        m_mcycle   = cyc_nx;
        m_minstret = ins_nx;
        if (trap) begin
            m_mepc   = (s.sex ? s.pcex : s.pcid) & ~32'h3;
            m_mcause = {27'b0, s.cause};
            m_mpie   = m_mie;
            m_mie    = 0;
        end else begin
            if (s.mret) begin
                m_mie  = m_mpie;
                m_mpie = 1;
            end
            if (wr) begin
                case (s.addr)
                    CSR_MSTATUS:  begin m_mie = nv[3]; m_mpie = nv[7]; end
                    CSR_MTVEC:    m_mtvec    = nv & ~32'h3;
                    CSR_MSCRATCH: m_mscratch = nv;
                    CSR_MEPC:     m_mepc     = nv & ~32'h3;
                    CSR_MCAUSE:   m_mcause   = nv;
                    default:      ;
                endcase
            end
        end
    endtask

    // One clock cycle: drive, check combinational read path, clock, check state outputs.
    task automatic cyc(input stim_t s, input string tag);
        drive(s);
        #2;
        check({tag, ":rdata"}, bus.csr_rdata_o, m_read(s.addr));
        check({tag, ":illegal"}, {31'b0, bus.illegal_csr_o}, {31'b0, m_illegal(s.op, s.addr)});
        @(posedge clk);
        model_edge(s);
        #1;
        check({tag, ":trap_target"}, trap_target, m_mtvec);
        check({tag, ":mepc_o"}, mepc, m_mepc);
        check({tag, ":mie_o"}, {31'b0, mie}, {31'b0, m_mie});
        drive(idle());
    endtask

    task automatic expect_read(input logic [11:0] a, input logic [31:0] exp, input string tag);
        bus.csr_op_i   = CSR_NONE;
        bus.csr_addr_i = a;
        #1;
        check(tag, bus.csr_rdata_o, exp);
    endtask

    task automatic probe_illegal(input csr_op_t op, input logic [11:0] a, input bit exp, input string tag);
        bus.csr_op_i   = op;
        bus.csr_addr_i = a;
        #1;
        check(tag, {31'b0, bus.illegal_csr_o}, {31'b0, exp});
        bus.csr_op_i = CSR_NONE;
    endtask

    logic [11:0] addr_tbl [10] = '{CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
                                   CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH, CSR_MHARTID};

    initial begin
        stim_t s;
        drive(idle());
        model_reset();

        // Reset
        #1 rst_n = 1'b0;
        #2;
        check("rst:trap_target", trap_target, 32'h100);
        check("rst:mepc_o", mepc, 32'h0);
        check("rst:mie_o", {31'b0, mie}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc(idle(), "first");
        expect_read(CSR_MCYCLE, 32'h1, "mcycle_first");

        // Read/modify/write on mscratch
        s = idle(); s.op = CSR_WRITE; s.addr = CSR_MSCRATCH; s.wdata = 32'hA5A5_0000;
        cyc(s, "wr_mscratch");
        expect_read(CSR_MSCRATCH, 32'hA5A5_0000, "mscratch_write");
        s.op = CSR_SET; s.wdata = 32'h0000_00FF;
        cyc(s, "set_mscratch");
        expect_read(CSR_MSCRATCH, 32'hA5A5_00FF, "mscratch_set");
        s.op = CSR_CLEAR; s.wdata = 32'hA500_0000;
        cyc(s, "clr_mscratch");
        expect_read(CSR_MSCRATCH, 32'h00A5_00FF, "mscratch_clear");

        // Trap priority with a colliding CSR write
        s = idle(); s.op = CSR_WRITE; s.addr = CSR_MSTATUS; s.wdata = 32'h8;
        cyc(s, "set_mie");
        expect_read(CSR_MSTATUS, 32'h1808, "mstatus_mie");
        s = idle(); s.sex = 1; s.sid = 1; s.pcex = 32'h84; s.pcid = 32'h40; s.cause = 5'd0;
        s.op = CSR_WRITE; s.addr = CSR_MSCRATCH; s.wdata = 32'hDEAD_BEEF;
        cyc(s, "trap");
        expect_read(CSR_MEPC, 32'h84, "trap_mepc");
        expect_read(CSR_MCAUSE, 32'h0, "trap_mcause");
        expect_read(CSR_MSTATUS, 32'h1880, "trap_mstatus");
        expect_read(CSR_MSCRATCH, 32'h00A5_00FF, "trap_mscratch_kept");

        // mret
        s = idle(); s.mret = 1;
        cyc(s, "mret");
        expect_read(CSR_MSTATUS, 32'h1888, "mret_mstatus");
        check("mret_mepc_o", mepc, 32'h84);
        check("mret_mie_o", {31'b0, mie}, 32'h1);

        // Illegal accesses
        probe_illegal(CSR_WRITE, CSR_MHARTID, 1'b1, "ill_wr_mhartid");
        probe_illegal(CSR_SET, 12'h7FF, 1'b1, "ill_set_7ff");
        probe_illegal(CSR_NONE, 12'h7FF, 1'b0, "none_7ff_legal");
        probe_illegal(CSR_NONE, CSR_MHARTID, 1'b0, "none_mhartid_legal");
        s = idle(); s.op = CSR_WRITE; s.addr = CSR_MHARTID; s.wdata = 32'h55;
        cyc(s, "wr_mhartid");
        s = idle(); s.op = CSR_CLEAR; s.addr = 12'h7FF; s.wdata = 32'hFFFF_FFFF;
        cyc(s, "clr_7ff");
        expect_read(CSR_MHARTID, MHARTID, "mhartid_kept");
        expect_read(CSR_MSCRATCH, 32'h00A5_00FF, "ill_mscratch_kept");
        expect_read(CSR_MSTATUS, 32'h1888, "ill_mstatus_kept");
        s = idle(); s.op = CSR_WRITE; s.addr = CSR_MTVEC; s.wdata = 32'h203;
        cyc(s, "wr_mtvec");
        expect_read(CSR_MTVEC, 32'h200, "mtvec_warl");
        check("trap_target_200", trap_target, 32'h200);

        // Counters
        s = idle(); s.op = CSR_WRITE; s.addr = CSR_MCYCLE; s.wdata = 32'hFFFF_FFFF;
        cyc(s, "wr_mcycle");
        s.addr = CSR_MCYCLEH;
        cyc(s, "wr_mcycleh");
        expect_read(CSR_MCYCLE, 32'hFFFF_FFFF, "mcycle_max_lo");
        expect_read(CSR_MCYCLEH, 32'hFFFF_FFFF, "mcycle_max_hi");
        cyc(idle(), "wrap");
        expect_read(CSR_MCYCLE, 32'h0, "mcycle_wrap_lo");
        expect_read(CSR_MCYCLEH, 32'h0, "mcycle_wrap_hi");
        s = idle(); s.op = CSR_WRITE; s.addr = CSR_MINSTRET; s.wdata = 32'h1234; s.ret = 1;
        cyc(s, "wr_minstret");
        expect_read(CSR_MINSTRET, 32'h1234, "minstret_override");
        cyc(idle(), "minstret_hold");
        expect_read(CSR_MINSTRET, 32'h1234, "minstret_no_retire");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            s       = idle();
            s.op    = csr_op_t'($urandom_range(0, 3));
            s.addr  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_tbl[$urandom_range(0, 9)];
            s.wdata = $urandom;
            s.sex   = ($urandom_range(0, 15) == 0);
            s.sid   = ($urandom_range(0, 15) == 0);
            s.pcid  = $urandom;
            s.pcex  = $urandom;
            s.cause = 5'($urandom_range(0, 31));
            s.mret  = ($urandom_range(0, 7) == 0);
            s.ret   = ($urandom_range(0, 1) == 1);
            if (s.mret && s.addr == CSR_MSTATUS) s.op = CSR_NONE;
            cyc(s, "rand");
        end

        // Reset in the middle of a write colliding with a trap
        s = idle(); s.op = CSR_WRITE; s.addr = CSR_MSCRATCH; s.wdata = 32'h1234_5678;
        s.sex = 1; s.pcex = 32'h44; s.cause = EXC_CAUSE_ILLEGAL_INSN;
        drive(s);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst:trap_target", trap_target, 32'h100);
        check("midrst:mepc_o", mepc, 32'h0);
        check("midrst:mie_o", {31'b0, mie}, 32'h0);
        check("midrst:mscratch", bus.csr_rdata_o, 32'h0);
        @(posedge clk);
        #1;
        check("midrst:mepc_hold", mepc, 32'h0);
        drive(idle());
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc(idle(), "after_rst");
        expect_read(CSR_MCYCLE, 32'h1, "mcycle_after_rst");
        expect_read(CSR_MSCRATCH, 32'h0, "mscratch_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 Parameter MTVEC_RST, default 32'h0000_0000, is the reset value of mtvec.
REQ-002 Parameter MHARTID, default 32'h0, is the value returned for mhartid.
REQ-003 clk_i  input  1  core clock; single clock domain.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 csr_op_i  input  csr_op_t  CSR access type: CSR_NONE, CSR_WRITE, CSR_SET or CSR_CLEAR.
REQ-006 csr_addr_i  input  12  CSR address.
REQ-007 csr_wdata_i  input  32  write, set or clear operand.
REQ-008 csr_rdata_o  output  32  current (pre-write) value of the addressed CSR.
REQ-009 illegal_csr_o  output  1  access is to an unimplemented CSR, or is a write to a read-only CSR.
REQ-010 save_pc_id_i / save_pc_ex_i  input  1 each  trap requests from the controller.
REQ-011 pc_id_i / pc_ex_i  input  32 each  PC of the instruction in ID / EX.
REQ-012 exception_cause_i  input  5  trap cause code.
REQ-013 is_mret_i  input  1  mret is committing.
REQ-014 instr_retired_i  input  1  one instruction retired this cycle.
REQ-015 trap_target_o  output  32  trap handler address, {mtvec[31:2],2'b00}.
REQ-016 mepc_o  output  32  mret return address.
REQ-017 mie_o  output  1  mstatus.MIE.

Function
REQ-018 csr_rdata_o and illegal_csr_o SHALL be combinational from csr_addr_i, csr_op_i and current state.
REQ-019 Implemented CSRs: mstatus, mtvec, mscratch, mepc, mcause, mcycle/mcycleh, minstret/minstreth, mhartid (read-only).
REQ-020 A CSR update SHALL take effect on the next clock edge; WRITE stores wdata, SET stores old|wdata, CLEAR stores old&~wdata.
REQ-021 An access with illegal_csr_o=1 SHALL leave all state unchanged.
REQ-022 Writes to csr_addr[11:10]==2'b11 SHALL be illegal. A CSR_NONE cycle SHALL never assert illegal_csr_o.
REQ-023 Bits [1:0] of mtvec and of mepc SHALL always read 0 (WARL; direct mode only).
REQ-024 mstatus SHALL implement only MIE[3], MPIE[7] and MPP[12:11]; MPP SHALL read 2'b11; all other bits SHALL read 0.
REQ-025 A trap (either save_pc input high) SHALL in one cycle set: mepc<=selected PC; mcause<={27'b0,cause}; MPIE<=MIE; MIE<=0.
REQ-026 save_pc_ex_i SHALL have priority over save_pc_id_i when both are high.
REQ-027 A trap in the same cycle as a CSR write or mret SHALL win; the write or mret is discarded.
REQ-028 mret SHALL set MIE<=MPIE and MPIE<=1, and SHALL leave mepc unchanged.
REQ-029 mcycle (64-bit) SHALL increment every cycle; minstret (64-bit) SHALL increment when instr_retired_i=1.
REQ-030 Both counters SHALL wrap from 2^64-1 to 0.
REQ-031 A CSR write to either counter half SHALL override that counter's increment in the same cycle; the other half SHALL hold.

Reset
REQ-032 On rst_n_i low, asynchronously: mstatus MIE=0 and MPIE=0; mtvec=MTVEC_RST; mscratch, mepc, mcause, mcycle and minstret=0.
REQ-033 Resulting output values during reset: trap_target_o={MTVEC_RST[31:2],2'b00}, mepc_o=0, mie_o=0.
REQ-034 A reset asserted mid-operation SHALL discard any in-flight write or trap.

Structure
REQ-035 csr_op_t, the CSR address constants and the mstatus bit indices SHALL be defined in core_pkg; the EXC_CAUSE_* constants already there SHALL be reused.
REQ-036 The two 64-bit counters SHALL be two instances of one sub-module, csr_counter64 (inputs: inc, wr_lo, wr_hi, wdata; output: 64-bit value).

Verification
REQ-037 Reset scenario: release reset with MTVEC_RST=32'h100 -> trap_target_o=32'h100, mepc_o=0, mie_o=0; mcycle reads 1 on the first cycle after release.
REQ-038 CSR ops scenario: CSR_WRITE mscratch=32'hA5A5_0000, then SET 32'hFF, then CLEAR 32'hA500_0000 -> reads 32'hA5A5_0000, 32'hA5A5_00FF, 32'h00A5_00FF.
REQ-039 Trap priority scenario: MIE=1; save_pc_ex_i and save_pc_id_i both high, pc_ex_i=32'h84, cause=0, plus a same-cycle mscratch write -> mepc=32'h84, mcause=0, MIE=0, MPIE=1, mscratch unchanged.
REQ-040 mret scenario: after the trap above, is_mret_i=1 -> MIE=1, MPIE=1, mepc_o=32'h84.
REQ-041 Illegal access scenario: write to mhartid, or any op to address 12'h7FF -> illegal_csr_o=1 and no state change; write mtvec=32'h203 -> reads 32'h200.
REQ-042 Counter scenario: write mcycle=32'hFFFF_FFFF and mcycleh=32'hFFFF_FFFF -> counter wraps to 0 on the next increment; write minstret with instr_retired_i=1 -> written value held, no increment that cycle.
